// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller.
// State encoding and SRAM geometry constants.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } sram_state_t;

  localparam int unsigned ADDR_BASE = 1024;
  localparam int SRAM_DW = 16;

endpackage

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller: one 32-bit load/store becomes two
// sequenced 16-bit SRAM accesses, low half first.
module mem_sram_ctrl #(
  parameter int unsigned ADDR_BASE = mem_ctrl_pkg::ADDR_BASE,
  parameter int SRAM_AW = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_en,
  input  logic                              wr_en,
  input  logic [31:0]                       address,
  input  logic [31:0]                       write_data,
  output logic [31:0]                       read_data,
  output logic                              ready,
  output logic [SRAM_AW-1:0]                sram_addr,
  output logic [mem_ctrl_pkg::SRAM_DW-1:0]  sram_dq_out,
  input  logic [mem_ctrl_pkg::SRAM_DW-1:0]  sram_dq_in,
  output logic                              sram_dq_oe,
  output logic                              sram_we_n
);

  import mem_ctrl_pkg::*;

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  sram_state_t r_state;
  sram_state_t w_next;

  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nx;
  logic                 r_wr;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_rdata;
  logic [SRAM_AW-1:0]   r_sram_addr;
  logic [SRAM_DW-1:0]   r_dq_out;
  logic                 r_oe;
  logic                 r_we_n;

  logic                 w_req;
  logic                 w_last;
  logic                 w_bus_wr;
  logic                 w_phase;
  logic [31:0]          w_addr_src;
  logic [31:0]          w_wd_src;
  logic [31:0]          w_off;
  logic [SRAM_AW-2:0]   w_hw_base;
  logic                 w_unused;

  assign w_req  = rd_en | wr_en;
  assign w_last = (r_cnt == LAST);

  // In IDLE the bus is set up from the live request, later from the latch
  assign w_addr_src = (r_state == IDLE) ? address : r_addr;
  assign w_wd_src   = (r_state == IDLE) ? write_data : r_wdata;
  assign w_bus_wr   = (r_state == IDLE) ? wr_en : r_wr;

  assign w_off     = w_addr_src - ADDR_BASE;
  assign w_hw_base = w_off[SRAM_AW:2];
  assign w_unused  = ^{w_off[31:SRAM_AW+1], w_off[1:0]};
  assign w_phase   = (w_next == LO) || (w_next == HI);

  assign ready = (r_state == IDLE) ? ~w_req : (r_state == DONE);

  assign read_data   = r_rdata;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_oe;
  assign sram_we_n   = r_we_n;

  always_comb begin
    w_next   = r_state;
    w_cnt_nx = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next   = LO;
          w_cnt_nx = '0;
        end
      end
      LO: begin
        if (w_last) begin
          w_next   = HI;
          w_cnt_nx = '0;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      HI: begin
        if (w_last) begin
          w_next   = DONE;
          w_cnt_nx = '0;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next   = IDLE;
        w_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_oe        <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nx;
      if (r_state == IDLE && w_req) begin
        r_wr    <= wr_en;
        r_addr  <= address;
        r_wdata <= write_data;
      end
      if (r_state == LO && w_last && !r_wr)
        r_rdata[15:0] <= sram_dq_in;
      if (r_state == HI && w_last && !r_wr)
        r_rdata[31:16] <= sram_dq_in;
      // Bus pins are registered against the state being entered
      r_oe   <= 1'b0;
      r_we_n <= 1'b1;
      if (w_phase) begin
        r_sram_addr <= {w_hw_base, (w_next == HI)};
        r_oe        <= w_bus_wr;
        r_we_n      <= ~w_bus_wr;
        if (w_bus_wr)
          r_dq_out <= (w_next == HI) ? w_wd_src[31:16]
                                     : w_wd_src[15:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl: one instance with two wait
// cycles per phase, one with a single wait cycle.
module tb_mem_sram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd0, wr0, rdy0, oe0, wen0;
  logic [31:0] addr0, wd0, rdata0;
  logic [17:0] saddr0;
  logic [15:0] dqo0, dqi0;

  logic        rd1, wr1, rdy1, oe1, wen1;
  logic [31:0] addr1, wd1, rdata1;
  logic [17:0] saddr1;
  logic [15:0] dqo1, dqi1;

  mem_sram_ctrl #(.WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0),
    .address(addr0), .write_data(wd0), .read_data(rdata0),
    .ready(rdy0), .sram_addr(saddr0), .sram_dq_out(dqo0),
    .sram_dq_in(dqi0), .sram_dq_oe(oe0), .sram_we_n(wen0)
  );

  mem_sram_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1),
    .address(addr1), .write_data(wd1), .read_data(rdata1),
    .ready(rdy1), .sram_addr(saddr1), .sram_dq_out(dqo1),
    .sram_dq_in(dqi1), .sram_dq_oe(oe1), .sram_we_n(wen1)
  );

  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];
  logic [15:0] shadow [64];

  assign dqi0 = mem0[saddr0[5:0]];
  assign dqi1 = mem1[saddr1[5:0]];

  always @(posedge clk) begin
    if (!wen0) mem0[saddr0[5:0]] <= dqo0;
    if (!wen1) mem1[saddr1[5:0]] <= dqo1;
  end

  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
  } wexp_t;

  wexp_t       wq0 [$];
  wexp_t       wq1 [$];
  logic [31:0] dq  [$];
  logic [31:0] last_rd;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] hw_of(input logic [31:0] a);
    logic [31:0] o;
    o = (a - 32'd1024) >> 2;
    return 18'(o << 1);
  endfunction

  task automatic push_wr(input int u, input logic [31:0] a,
                         input logic [31:0] d);
    wexp_t e;
    int w;
    w = (u == 0) ? 2 : 1;
    for (int i = 0; i < 2 * w; i++) begin
      e.a = (i < w) ? hw_of(a) : (hw_of(a) | 18'd1);
      e.d = (i < w) ? d[15:0] : d[31:16];
      if (u == 0) wq0.push_back(e);
      else        wq1.push_back(e);
    end
  endtask

  task automatic do_acc(input int u, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
    logic [5:0] i0;
    logic r;
    i0 = hw_of(a)[5:0];
    @(posedge clk); #1;
    if (u == 0) begin
      rd0 = rd; wr0 = wr; addr0 = a; wd0 = d;
    end else begin
      rd1 = rd; wr1 = wr; addr1 = a; wd1 = d;
    end
    if (wr) push_wr(u, a, d);
    if (u == 0) begin
      if (wr) begin
        shadow[i0]        = d[15:0];
        shadow[i0 | 6'd1] = d[31:16];
      end else begin
        last_rd = {shadow[i0 | 6'd1], shadow[i0]};
      end
      dq.push_back(last_rd);
    end
    r = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      r = (u == 0) ? rdy0 : rdy1;
      if (r) break;
    end
    if (!r) chk("timeout", 32'(r), 32'd1);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
    repeat (n) @(posedge clk);
  endtask

  int   low0  = 0;
  logic prev0 = 1'b1;

  always @(negedge clk) begin : mon0
    wexp_t e;
    if (!rst) begin
      prev0 = 1'b1;
      low0  = 0;
    end else begin
      if (!wen0) begin
        if (wq0.size() == 0) begin
          chk("wr_unexp0", 32'(wen0), 32'd1);
        end else begin
          e = wq0.pop_front();
          chk("addr0", 32'(saddr0), 32'(e.a));
          chk("dq0", 32'(dqo0), 32'(e.d));
          chk("oe_wr0", 32'(oe0), 32'd1);
        end
      end else begin
        chk("oe_off0", 32'(oe0), 32'd0);
      end
      if (rdy0 && !prev0) begin
        if (dq.size() == 0) chk("done_unexp", 32'd0, 32'd1);
        else chk("rdata", rdata0, dq.pop_front());
        chk("stall", 32'(low0), 32'd5);
      end
      low0  = rdy0 ? 0 : low0 + 1;
      prev0 = rdy0;
    end
  end

  int   cyc1   = 0;
  int   tdone1 = 0;
  logic prev1  = 1'b1;

  always @(negedge clk) begin : mon1
    wexp_t e;
    cyc1++;
    if (!rst) begin
      prev1 = 1'b1;
    end else begin
      if (!wen1) begin
        if (wq1.size() == 0) begin
          chk("wr_unexp1", 32'(wen1), 32'd1);
        end else begin
          e = wq1.pop_front();
          chk("addr1", 32'(saddr1), 32'(e.a));
          chk("dq1", 32'(dqo1), 32'(e.d));
          chk("oe_wr1", 32'(oe1), 32'd1);
          if (e.a == 18'd4) chk("b2b_gap", 32'(cyc1 - tdone1), 32'd2);
        end
      end else begin
        chk("oe_off1", 32'(oe1), 32'd0);
      end
      if (rdy1 && !prev1) tdone1 = cyc1;
      prev1 = rdy1;
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem0[i] = '0; mem1[i] = '0; shadow[i] = '0;
    end
    last_rd = '0;
    rd0 = 0; wr0 = 0; addr0 = '0; wd0 = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; wd1 = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", 32'(wen0), 32'd1);
    chk("rst_oe", 32'(oe0), 32'd0);
    chk("rst_rdy", 32'(rdy0), 32'd1);
    chk("rst_rdata", rdata0, 32'd0);
    chk("rst_addr", 32'(saddr0), 32'd0);
    rd0 = 1;
    #1 chk("rst_rdy_req", 32'(rdy0), 32'd0);
    rd0 = 0;
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_rdy", 32'(rdy0), 32'd1);
      chk("idle_wen", 32'(wen0), 32'd1);
      chk("idle_oe", 32'(oe0), 32'd0);
    end

    do_acc(0, 0, 1, 32'd1028, 32'hDEADBEEF);
    idle(2);
    do_acc(0, 1, 0, 32'd1028, 32'h0);
    idle(1);
    do_acc(0, 1, 0, 32'd1029, 32'h0);
    idle(1);
    do_acc(0, 1, 1, 32'd1024, 32'h12345678);
    idle(1);
    do_acc(0, 1, 0, 32'd1024, 32'h0);
    do_acc(0, 0, 1, 32'd1020, 32'hA5A55A5A);
    do_acc(0, 1, 0, 32'd1020, 32'h0);
    idle(2);

    @(posedge clk); #1;
    wr0 = 1; addr0 = 32'd1040; wd0 = 32'hCAFEF00D;
    push_wr(0, 32'd1040, 32'hCAFEF00D);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_hi", 32'(saddr0), 32'(hw_of(32'd1040) | 18'd1));
    rst = 1'b0;
    wr0 = 0;
    #1;
    chk("arst_wen", 32'(wen0), 32'd1);
    chk("arst_oe", 32'(oe0), 32'd0);
    chk("arst_rdy", 32'(rdy0), 32'd1);
    chk("arst_rdata", rdata0, 32'd0);
    wq0.delete();
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    do_acc(0, 1, 0, 32'd1028, 32'h0);
    idle(1);

    do_acc(1, 0, 1, 32'd1024, 32'h11112222);
    do_acc(1, 0, 1, 32'd1032, 32'h33334444);
    idle(3);

    chk("wq0_left", 32'(wq0.size()), 32'd0);
    chk("wq1_left", 32'(wq1.size()), 32'd0);
    chk("dq_left", 32'(dq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=%h exp=%h", 0, 1);
    $fatal(1, "watchdog");
  end

endmodule
